// File: rtl/modex_engine.sv
// Modular exponentiation engine: result = base^exponent mod modulus, using MSB-first square-and-multiply
// over a bit-serial shift-add modular multiplier. Optional macro MODEX_CYCLE_COUNT_EN adds a 32-bit cycle count port.
`timescale 1ns/1ps
module modex_engine #(
    parameter int W    = 16,
    parameter int EXPW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    base,
    input  logic [EXPW-1:0] exponent,
    input  logic [W-1:0]    modulus,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    result,
    output logic            err
`ifdef MODEX_CYCLE_COUNT_EN
    ,
    output logic [31:0]     cycles
`endif
);

    localparam int IDXW = (EXPW > 1) ? $clog2(EXPW) : 1;
    localparam int CNTW = (W > 1) ? $clog2(W) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_ERR   = 3'd2;
    localparam logic [2:0] S_SQR   = 3'd3;
    localparam logic [2:0] S_MUL   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]      state_q, state_d;
    logic [W-1:0]    base_q, base_d;
    logic [W-1:0]    mod_q, mod_d;
    logic [EXPW-1:0] exp_q, exp_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [W:0]      p_q, p_d;
    logic [CNTW-1:0] step_q, step_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [W-1:0]    result_q, result_d;
    logic            err_q, err_d;
`ifdef MODEX_CYCLE_COUNT_EN
    logic [31:0]     cyc_q, cyc_d;
`endif

    logic [W-1:0]    mul_b;
    logic [W:0]      p_next;
    logic            last_step;

    // One interleaved step: double, reduce, conditionally add b, reduce. Inputs are always < n.
    function automatic logic [W:0] mod_step(input logic [W:0] p, input logic a_bit,
                                            input logic [W-1:0] b, input logic [W-1:0] n);
        logic [W:0] t;
        logic [W:0] n_ext;
        n_ext = {1'b0, n};
        t     = {p[W-1:0], 1'b0};
        if (t >= n_ext) t = t - n_ext;
        if (a_bit) begin
            t = t + {1'b0, b};
            if (t >= n_ext) t = t - n_ext;
        end
        return t;
    endfunction

    assign mul_b     = (state_q == S_MUL) ? base_q : acc_q;
    assign p_next    = mod_step(p_q, acc_q[step_q], mul_b, mod_q);
    assign last_step = (step_q == '0);

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        mod_d    = mod_q;
        exp_d    = exp_q;
        acc_d    = acc_q;
        p_d      = p_q;
        step_d   = step_q;
        idx_d    = idx_q;
        result_d = result_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    base_d  = base;
                    exp_d   = exponent;
                    mod_d   = modulus;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if ((mod_q <= W'(1)) || (base_q >= mod_q)) begin
                    err_d    = 1'b1;
                    result_d = '0;
                    state_d  = S_ERR;
                end else begin
                    err_d   = 1'b0;
                    acc_d   = W'(1);
                    p_d     = '0;
                    step_d  = CNTW'(W - 1);
                    idx_d   = IDXW'(EXPW - 1);
                    state_d = S_SQR;
                end
            end
            // Extra cycle keeps the rejection latency fixed at two cycles.
            S_ERR: state_d = S_DONE;
            S_SQR, S_MUL: begin
                p_d    = p_next;
                step_d = step_q - 1'b1;
                if (last_step) begin
                    acc_d  = p_next[W-1:0];
                    p_d    = '0;
                    step_d = CNTW'(W - 1);
                    // Exponent bit advance happens here, so it costs no separate cycle.
                    if ((state_q == S_SQR) && exp_q[idx_q]) begin
                        state_d = S_MUL;
                    end else if (idx_q == '0) begin
                        result_d = p_next[W-1:0];
                        state_d  = S_DONE;
                    end else begin
                        idx_d   = idx_q - 1'b1;
                        state_d = S_SQR;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef MODEX_CYCLE_COUNT_EN
    always_comb begin
        cyc_d = cyc_q;
        if ((state_q == S_IDLE) && in_valid) begin
            cyc_d = '0;
        end else if (((state_q == S_CHECK) || (state_q == S_ERR) || (state_q == S_SQR) ||
                      (state_q == S_MUL)) && (state_d != S_DONE)) begin
            cyc_d = cyc_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cyc_q <= '0;
        else      cyc_q <= cyc_d;
    end

    assign cycles = cyc_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            mod_q    <= '0;
            exp_q    <= '0;
            acc_q    <= '0;
            p_q      <= '0;
            step_q   <= '0;
            idx_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            mod_q    <= mod_d;
            exp_q    <= exp_d;
            acc_q    <= acc_d;
            p_q      <= p_d;
            step_q   <= step_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign err       = err_q;

endmodule

// File: doc/modex_engine.md
Name: modex_engine

Overview:
- Parametrised modular-exponentiation engine: computes result = base^exponent mod modulus.
- Uses MSB-first square-and-multiply over interleaved shift-add modular multiplication.
- Successor to the fixed-width MODEX datapath: generic operand and exponent widths, valid/ready handshakes on both sides, and error signalling.
- Sits between the ciphertext ROM/address sequencer and the plaintext sink in the RSA decryption path.

Parameters:
- W, 16: operand width in bits for base, modulus and result.
- EXPW, 16: exponent width in bits; all EXPW bits are scanned, with no leading-zero skip.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  engine can accept a request (high only in IDLE).
- base  in  W  message/ciphertext operand.
- exponent  in  EXPW  exponent (e or d).
- modulus  in  W  modulus n.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  W  base^exponent mod modulus.
- err  out  1  qualifies result: operand error, with result forced to 0.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; in_ready=1; out_valid=0; result=0; err=0; all internal registers cleared. Reset mid-operation aborts the computation; nothing is emitted.
- Accept: in_valid&&in_ready on a rising edge latches base, exponent and modulus; next state is CHECK. Inputs are ignored at all other times.
- CHECK (1 cycle):
  - modulus<2, or base>=modulus: go to DONE with err=1, result=0.
  - otherwise: acc=1, bit index=EXPW-1, go to SQR.
- SQR (W cycles): acc=acc*acc mod n.
- MUL (W cycles): acc=acc*base mod n.
- Modular multiply a*b mod n, W cycles, i from W-1 down to 0:
  - P=2P; if P>=n then P-=n.
  - if a[i]: P+=b; if P>=n then P-=n.
  - P is held in W+1 bits internally; operands are always <n, so one conditional subtract per step suffices.
- Bit sequencing:
  - After SQR: if exponent[idx]=1 go to MUL, else go to NEXT.
  - After MUL, go to NEXT.
  - NEXT is folded into the last multiply cycle and adds no cycle: if idx==0 go to DONE, else idx-=1 and go to SQR.
- The first squaring of acc=1 is performed anyway, for fixed timing.
- exponent=0 yields result=1 (modulus>=2 is guaranteed).
- Latency: out_valid rises exactly 1+W*(EXPW+popcount(exponent)) cycles after the accepting edge. The error path takes 2 cycles.
- DONE:
  - out_valid=1; result and err are stable while out_valid&&!out_ready (backpressure holds indefinitely).
  - On out_valid&&out_ready: out_valid=0, go to IDLE, in_ready=1 on the next cycle.
  - No accept occurs in the same cycle as output retirement.
- in_ready=0 in every state except IDLE.
- in_valid held high continuously: back-to-back requests are accepted one cycle after each retirement.

Optional Feature:
- Macro: MODEX_CYCLE_COUNT_EN.
- Defined:
  - Adds output port cycles (32 bits). A counter resets to 0 on accept and increments each cycle in CHECK/SQR/MUL.
  - The count is frozen and valid alongside out_valid, and held through backpressure; reset value 0.
  - Value equals latency-1, e.g. 288 for the W=16 test with popcount 2.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- W=16, EXPW=16: base=2, exp=10, mod=1000 -> result=24, err=0; out_valid exactly 289 cycles after accept.
- RSA round trip: (65, 17, 3233) -> 2790, then (2790, 2753, 3233) -> 65; check latency for each against the formula.
- Edge operands:
  - exp=0, base=7, mod=11 -> result=1.
  - base=0, exp=5, mod=11 -> result=0.
  - mod=0xFFFF, base=0xFFFE, exp=2 -> result=1.
- Errors:
  - mod=1 -> err=1, result=0, out_valid 2 cycles after accept.
  - base=20, mod=11 -> err=1.
- Backpressure: hold out_ready=0 for 50 cycles -> result/err stable, in_ready=0, new in_valid ignored. Then pulse out_ready -> retire, in_ready=1 the next cycle.
- Reset during SQR of a long request -> all outputs at reset values, no out_valid. A following request (2, 10, 1000) returns 24 correctly.
